// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame
// clocked by the device, acknowledge check and a watchdog on the whole exchange.
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kbclk_in,
    input  logic       kbdata_in,
    output logic       kbclk_oe,
    output logic       kbdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BIT_W = 4;

    typedef enum logic [1:0] {IDLE, INHIBIT, SEND, WAIT_IDLE} state_t;

    state_t             state, state_nxt;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt, bit_inc;
    logic [7:0]         shreg, shreg_nxt;
    logic               parity, parity_nxt;
    logic               kbclk_oe_nxt, kbdata_oe_nxt;
    logic               done_nxt, ack_err_nxt, timeout_nxt;
    logic               clk_s1, clk_s2, clk_s3;
    logic               dat_s1, dat_s2;
    logic               fall, to_expire;

    // Pad synchronizers; idle bus level is high so they reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kbclk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= kbdata_in;
            dat_s2 <= dat_s1;
        end
    end

    assign fall      = ~clk_s2 & clk_s3;
    assign to_expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign bit_inc   = bit_cnt + BIT_W'(1);
    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            kbclk_oe  <= 1'b0;
            kbdata_oe <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            inh_cnt   <= inh_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            parity    <= parity_nxt;
            kbclk_oe  <= kbclk_oe_nxt;
            kbdata_oe <= kbdata_oe_nxt;
            done      <= done_nxt;
            ack_err   <= ack_err_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state and next-output decode; the watchdog outranks any bus event
    always_comb begin
        state_nxt     = state;
        inh_cnt_nxt   = inh_cnt;
        to_cnt_nxt    = to_cnt;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        parity_nxt    = parity;
        kbclk_oe_nxt  = kbclk_oe;
        kbdata_oe_nxt = kbdata_oe;
        done_nxt      = 1'b0;
        ack_err_nxt   = 1'b0;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                kbclk_oe_nxt  = 1'b0;
                kbdata_oe_nxt = 1'b0;
                if (tx_valid) begin
                    shreg_nxt    = tx_data;
                    parity_nxt   = ~^tx_data;
                    inh_cnt_nxt  = '0;
                    kbclk_oe_nxt = 1'b1;
                    state_nxt    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    kbclk_oe_nxt  = 1'b0;
                    kbdata_oe_nxt = 1'b1;
                    bit_cnt_nxt   = '0;
                    to_cnt_nxt    = '0;
                    state_nxt     = SEND;
                end else begin
                    inh_cnt_nxt = inh_cnt + INH_W'(1);
                end
            end
            SEND: begin
                if (to_expire) begin
                    timeout_nxt   = 1'b1;
                    kbclk_oe_nxt  = 1'b0;
                    kbdata_oe_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    if (fall) begin
                        bit_cnt_nxt = bit_inc;
                        if (bit_inc <= BIT_W'(8)) begin
                            kbdata_oe_nxt = ~shreg[0];
                            shreg_nxt     = {1'b0, shreg[7:1]};
                        end else if (bit_inc == BIT_W'(9)) begin
                            kbdata_oe_nxt = ~parity;
                        end else if (bit_inc == BIT_W'(10)) begin
                            kbdata_oe_nxt = 1'b0;
                        end else begin
                            kbdata_oe_nxt = 1'b0;
                            if (dat_s2) begin
                                ack_err_nxt = 1'b1;
                                state_nxt   = IDLE;
                            end else begin
                                state_nxt   = WAIT_IDLE;
                            end
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                kbclk_oe_nxt  = 1'b0;
                kbdata_oe_nxt = 1'b0;
                if (to_expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    if (clk_s2 && dat_s2) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                kbclk_oe_nxt  = 1'b0;
                kbdata_oe_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a behavioural PS/2 device that clocks
// frames in, plus a frame model built from the start/data/odd-parity/stop rules.
module tb_ps2_tx;

    localparam int unsigned INH = 10;
    localparam int unsigned TO  = 2000;
    localparam int unsigned H   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_err, timeout;
    logic       kbclk_oe, kbdata_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbclk_line, kbdata_line;

    assign kbclk_line  = ~(kbclk_oe | dev_clk_low);
    assign kbdata_line = ~(kbdata_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .kbclk_in  (kbclk_line),
        .kbdata_in (kbdata_line),
        .kbclk_oe  (kbclk_oe),
        .kbdata_oe (kbdata_oe),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus monitor: pulse counts, inhibit length, timeout latency
    int   cyc = 0, run = 0, last_run = 0, n_inhibit = 0;
    int   done_cnt = 0, ack_cnt = 0, to_seen = 0;
    int   t_send = 0, t_to = 0;
    logic prev_clk_oe = 1'b0, start_seen = 1'b0;
    logic to_data_oe = 1'b1, to_ready = 1'b0;
    logic pend = 1'b0, post_ok = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (kbclk_oe) run++;
        else begin
            if (prev_clk_oe) begin
                last_run   = run;
                start_seen = kbdata_oe;
                t_send     = cyc;
                n_inhibit++;
            end
            run = 0;
        end
        prev_clk_oe = kbclk_oe;
        if (pend) begin
            post_ok = tx_ready && !kbclk_oe && !kbdata_oe;
            pend    = 1'b0;
        end
        if (done)    done_cnt++;
        if (ack_err) ack_cnt++;
        if (timeout) begin
            to_seen++;
            t_to       = cyc;
            to_data_oe = kbdata_oe;
            to_ready   = tx_ready;
        end
        if (done || ack_err || timeout) pend = 1'b1;
    end

    function automatic logic [10:0] frame(input logic [7:0] b);
        int          ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_bus(input logic clk_lvl, input bit use_data, input logic data_lvl,
                            output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (kbclk_line == clk_lvl && (!use_data || kbdata_line == data_lvl)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device side: wait for request-to-send, then clock the frame in
    task automatic device(input int pulses, input bit ack, output logic [10:0] bits,
                          output bit ok);
        bit w;
        bits = '0;
        ok   = 1'b0;
        wait_bus(1'b0, 1'b0, 1'b0, w);
        if (!w) return;
        wait_bus(1'b1, 1'b1, 1'b0, w);
        if (!w) return;
        repeat (H) @(posedge clk);
        bits[0] = kbdata_line;
        for (int k = 1; k <= pulses && k <= 11; k++) begin
            #2;
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(posedge clk);
            #2;
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = kbdata_line;
            dev_data_low = 1'b0;
            if (k < pulses) repeat (H) @(posedge clk);
        end
        ok = 1'b1;
    endtask

    task automatic drive_accept(input logic [7:0] b);
        bit w = 1'b0;
        for (int t = 0; t < 5000 && !w; t++) begin
            @(negedge clk);
            w = tx_ready;
        end
        check("ready_wait", 32'(w), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check("accept_clk_oe", 32'(kbclk_oe), 32'd1);
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic transfer(input logic [7:0] b, input bit ack, input bit inject);
        logic [10:0] bits;
        bit          ok;
        int          d0, a0, t0;
        d0 = done_cnt; a0 = ack_cnt; t0 = to_seen;
        post_ok = 1'b0;
        fork
            device(11, ack, bits, ok);
            begin
                drive_accept(b);
                if (inject) begin
                    repeat (50) @(posedge clk);
                    #1 tx_data = 8'hAA; tx_valid = 1'b1;
                    repeat (100) @(posedge clk);
                    #1 tx_valid = 1'b0;
                end
            end
        join
        repeat (10) @(negedge clk);
        check("dev_ok", 32'(ok), 32'd1);
        check("frame", 32'(bits), 32'(frame(b)));
        check("inhibit_len", 32'(last_run), 32'(INH));
        check("start_same_edge", 32'(start_seen), 32'd1);
        check("done_cnt", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check("ack_err_cnt", 32'(ack_cnt - a0), ack ? 32'd0 : 32'd1);
        check("timeout_cnt", 32'(to_seen - t0), 32'd0);
        check("post_pulse_idle", 32'(post_ok), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] b1, b2;
        bit          ok1, ok2, w;
        int          d0, a0, t0, n0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_kbclk_oe", 32'(kbclk_oe), 32'd0);
        check("rst_kbdata_oe", 32'(kbdata_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        transfer(8'hED, 1'b1, 1'b1);
        transfer(8'hF4, 1'b1, 1'b0);
        transfer(8'h00, 1'b1, 1'b0);
        transfer(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) transfer(8'($urandom), 1'b1, 1'b0);

        // Back-to-back: tx_valid held across two frames
        d0 = done_cnt; n0 = n_inhibit;
        fork
            begin
                device(11, 1'b1, b1, ok1);
                device(11, 1'b1, b2, ok2);
            end
            begin
                @(negedge clk);
                tx_data = 8'h3C; tx_valid = 1'b1;
                @(posedge clk);
                #1 tx_data = 8'hC5;
                w = 1'b0;
                for (int t = 0; t < 5000 && !w; t++) begin
                    @(negedge clk);
                    if (tx_ready) begin
                        @(posedge clk);
                        #1 w = 1'b1;
                    end
                end
                tx_valid = 1'b0;
                check("b2b_second_accept", 32'(w), 32'd1);
            end
        join
        repeat (10) @(negedge clk);
        check("b2b_frame1", 32'(b1), 32'(frame(8'h3C)));
        check("b2b_frame2", 32'(b2), 32'(frame(8'hC5)));
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_inhibits", 32'(n_inhibit - n0), 32'd2);

        // No device activity: watchdog must fire
        d0 = done_cnt; a0 = ack_cnt; t0 = to_seen;
        drive_accept(8'h42);
        w = 1'b0;
        for (int t = 0; t < 3000 && !w; t++) begin
            @(negedge clk);
            w = (to_seen != t0);
        end
        check("timeout_seen", 32'(w), 32'd1);
        check("timeout_latency", 32'(t_to - t_send), 32'(TO));
        check("timeout_data_oe", 32'(to_data_oe), 32'd0);
        check("timeout_idle", 32'(to_ready), 32'd1);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_no_ack", 32'(ack_cnt - a0), 32'd0);

        // Reset after fall 4 of 0xFF
        d0 = done_cnt; a0 = ack_cnt; t0 = to_seen;
        fork
            device(4, 1'b1, b1, ok1);
            drive_accept(8'hFF);
        join
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_kbclk_oe", 32'(kbclk_oe), 32'd0);
        check("mid_rst_kbdata_oe", 32'(kbdata_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_status", 32'((done_cnt - d0) + (ack_cnt - a0) + (to_seen - t0)), 32'd0);
        transfer(8'hFF, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
